blend_threshold_gen: RTL

BLEND_THRESHOLD_GEN -- requirements
Module: blend_threshold_gen

---
 rtl/blend_pkg.sv | 7 +
 rtl/minmax_tree.sv | 22 ++
 rtl/blend_threshold_gen.sv | 104 ++++++++++
 3 files changed

// File: rtl/blend_pkg.sv
// Shared defaults and pixel type for the blend threshold generator.
package blend_pkg;
  localparam int DW_DEF  = 8;
  localparam int WIN_DEF = 4;

  typedef logic [DW_DEF-1:0] pix_t;
endpackage

// File: rtl/minmax_tree.sv
// Combinational unsigned min/max reduction over a WIN-entry pixel window.
module minmax_tree
  import blend_pkg::*;
#(
  parameter int DW  = DW_DEF,
  parameter int WIN = WIN_DEF
) (
  input  logic [WIN-1:0][DW-1:0] win_i,
  output logic [DW-1:0]          min_o,
  output logic [DW-1:0]          max_o
);

  always_comb begin
    min_o = win_i[0];
    max_o = win_i[0];
    for (int i = 1; i < WIN; i++) begin
      if (win_i[i] < min_o) min_o = win_i[i];
      if (win_i[i] > max_o) max_o = win_i[i];
    end
  end

endmodule

// File: rtl/blend_threshold_gen.sv
// Sliding-window min/max blend threshold generator, 2-stage pipeline.
// Optional threshold widening by a margin input when BLEND_TH_MARGIN_EN is defined.
module blend_threshold_gen
  import blend_pkg::*;
#(
  parameter int DW  = DW_DEF,
  parameter int WIN = WIN_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_pix,
  input  logic          in_sol,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_pix,
  output logic [DW-1:0] out_th0,
  output logic [DW-1:0] out_th1
`ifdef BLEND_TH_MARGIN_EN
  ,
  input  logic [DW-1:0] margin
`endif
);

  // Handshake: a beat transfers when valid && ready on a rising edge. in_ready
  // is a global pipeline enable derived only from registered out_valid and out_ready.
  logic                   en;
  logic                   accept;
  logic                   first_q;
  logic [WIN-1:0][DW-1:0] win_q, win_d;
  logic                   s1_valid_q;
  logic [DW-1:0]          s1_pix_q;
  logic                   out_valid_q;
  logic [DW-1:0]          out_pix_q, th0_q, th1_q;
  logic [DW-1:0]          min_w, max_w, th0_d, th1_d;

  assign en     = !out_valid_q || out_ready;
  assign accept = in_valid && en;

  // Start of line (or first pixel after reset) replicates the pixel across the window.
  always_comb begin
    win_d = win_q;
    if (accept) begin
      if (in_sol || first_q) begin
        for (int i = 0; i < WIN; i++) win_d[i] = in_pix;
      end else begin
        win_d[0] = in_pix;
        for (int i = 1; i < WIN; i++) win_d[i] = win_q[i-1];
      end
    end
  end

  minmax_tree #(.DW(DW), .WIN(WIN)) u_minmax (
    .win_i (win_q),
    .min_o (min_w),
    .max_o (max_w)
  );

`ifdef BLEND_TH_MARGIN_EN
  logic [DW:0] hi_sum;
  always_comb begin
    hi_sum = {1'b0, max_w} + {1'b0, margin};
    th1_d  = hi_sum[DW] ? '1 : hi_sum[DW-1:0];
    th0_d  = (min_w > margin) ? (min_w - margin) : '0;
  end
`else
  always_comb begin
    th0_d = min_w;
    th1_d = max_w;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_q     <= 1'b1;
      win_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_pix_q    <= '0;
      out_valid_q <= 1'b0;
      out_pix_q   <= '0;
      th0_q       <= '0;
      th1_q       <= '0;
    end else if (en) begin
      win_q       <= win_d;
      s1_valid_q  <= in_valid;
      out_valid_q <= s1_valid_q;
      out_pix_q   <= s1_pix_q;
      th0_q       <= th0_d;
      th1_q       <= th1_d;
      if (accept) begin
        first_q  <= 1'b0;
        s1_pix_q <= in_pix;
      end
    end
  end

  assign in_ready  = en;
  assign out_valid = out_valid_q;
  assign out_pix   = out_pix_q;
  assign out_th0   = th0_q;
  assign out_th1   = th1_q;

endmodule
